// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch stage.
//   EX_WIDTH               exception_out is EX_WIDTH+1 bits wide
//   EX_INSTR_MISALIGNED    code raised when the PC is not word aligned
//   EX_INSTR_ACCESS_FAULT  code raised when memory flags a response error
//   NOP_INSTR              instruction presented when no real word exists
//   fetch_state_t          fetch sequencer states
//   pc_incr()              sequential PC step, wrapping mod 2^32
package fetch_pkg;

  localparam int EX_WIDTH = 3;

  typedef logic [EX_WIDTH:0] ex_code_t;

  localparam ex_code_t    EX_INSTR_MISALIGNED   = ex_code_t'(0);
  localparam ex_code_t    EX_INSTR_ACCESS_FAULT = ex_code_t'(1);
  localparam logic [31:0] NOP_INSTR             = 32'h0000_0013;

  typedef enum logic [2:0] {
    S_REQ  = 3'd0,
    S_WAIT = 3'd1,
    S_HOLD = 3'd2,
    S_DROP = 3'd3,
    S_PARK = 3'd4
  } fetch_state_t;

  function automatic logic [31:0] pc_incr(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/fetch.sv
// Instruction fetch stage. Owns the PC, issues one word request at a time to
// instruction memory and registers {PC, instr, exception} for decode.
//
// Optional feature: define FETCH_PERF_CNT_EN to add fetch_count, a wrapping
// count of clean (non-exception) items handed to decode.
//
// Ports:
//   clk, reset              clock; asynchronous active-high reset
//   imem_req_valid/ready    request handshake, imem_addr = current PC
//   imem_resp_valid/data/err  response from memory (err = access fault)
//   PC_out, instr_out       item presented to decode
//   exception_out(_valid)   exception code attached to the item
//   pipeline_out_valid      a new item is presented this cycle
//   stall                   decode cannot accept; outputs hold
//   flush, redirect_pc      discard in-flight work and restart at redirect_pc
//   fetch_count             (FETCH_PERF_CNT_EN only) clean items delivered
module fetch
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            reset,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [31:0]     imem_addr,
  input  logic            imem_resp_valid,
  input  logic [31:0]     imem_resp_data,
  input  logic            imem_resp_err,
  output logic [31:0]     PC_out,
  output logic [31:0]     instr_out,
  output logic [EX_WIDTH:0] exception_out,
  output logic            exception_out_valid,
  output logic            pipeline_out_valid,
  input  logic            stall,
  input  logic            flush,
  input  logic [31:0]     redirect_pc
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]     fetch_count
`endif
);

  fetch_state_t state_q, state_d;
  logic [31:0]  pc_q, pc_d;

  logic [31:0]  pc_out_q, pc_out_d;
  logic [31:0]  instr_q, instr_d;
  ex_code_t     exc_q, exc_d;
  logic         exc_vld_q, exc_vld_d;
  logic         pov_q, pov_d;

  // Hold buffer: a response that arrived while decode was stalled.
  logic         hold_vld_q, hold_vld_d;
  logic [31:0]  hold_data_q, hold_data_d;
  logic         hold_err_q, hold_err_d;
  logic [31:0]  hold_pc_q, hold_pc_d;

  logic         handshake;
  logic         deliver;
  logic [31:0]  item_data;
  logic         item_err;
  logic [31:0]  item_pc;

  assign imem_req_valid = (state_q == S_REQ) && (pc_q[1:0] == 2'b00);
  assign imem_addr      = pc_q;
  assign handshake      = imem_req_valid && imem_req_ready;

  assign PC_out              = pc_out_q;
  assign instr_out           = instr_q;
  assign exception_out       = exc_q;
  assign exception_out_valid = exc_vld_q;
  assign pipeline_out_valid  = pov_q;

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    pc_out_d    = pc_out_q;
    instr_d     = instr_q;
    exc_d       = exc_q;
    exc_vld_d   = exc_vld_q;
    // A stalled decode keeps seeing the same item; otherwise valid is a pulse.
    pov_d       = stall ? pov_q : 1'b0;
    hold_vld_d  = hold_vld_q;
    hold_data_d = hold_data_q;
    hold_err_d  = hold_err_q;
    hold_pc_d   = hold_pc_q;
    deliver     = 1'b0;
    item_data   = imem_resp_data;
    item_err    = imem_resp_err;
    item_pc     = pc_q;

    if (flush) begin
      pc_d       = redirect_pc;
      pov_d      = 1'b0;
      hold_vld_d = 1'b0;
      // A response still owed by memory must be swallowed before re-requesting.
      if ((state_q == S_WAIT && !imem_resp_valid) ||
          (state_q == S_DROP && !imem_resp_valid) ||
          (state_q == S_REQ  && handshake)) begin
        state_d = S_DROP;
      end else begin
        state_d = S_REQ;
      end
    end else begin
      unique case (state_q)
        S_REQ: begin
          if (pc_q[1:0] != 2'b00) begin
            if (!stall) begin
              pc_out_d  = pc_q;
              instr_d   = NOP_INSTR;
              exc_d     = EX_INSTR_MISALIGNED;
              exc_vld_d = 1'b1;
              pov_d     = 1'b1;
              state_d   = S_PARK;
            end
          end else if (handshake) begin
            state_d = S_WAIT;
          end
        end
        S_WAIT: begin
          if (imem_resp_valid) begin
            if (stall) begin
              hold_vld_d  = 1'b1;
              hold_data_d = imem_resp_data;
              hold_err_d  = imem_resp_err;
              hold_pc_d   = pc_q;
              state_d     = S_HOLD;
            end else begin
              deliver = 1'b1;
            end
          end
        end
        S_HOLD: begin
          item_data = hold_data_q;
          item_err  = hold_err_q;
          item_pc   = hold_pc_q;
          if (!stall && hold_vld_q) begin
            deliver    = 1'b1;
            hold_vld_d = 1'b0;
          end
        end
        S_DROP: begin
          if (imem_resp_valid) begin
            state_d = S_REQ;
          end
        end
        S_PARK: begin
          state_d = S_PARK;
        end
        default: begin
          state_d = S_REQ;
        end
      endcase

      if (deliver) begin
        pc_out_d = item_pc;
        pov_d    = 1'b1;
        if (item_err) begin
          // Faulting fetch: the PC stays on the faulting word and fetch parks.
          instr_d   = NOP_INSTR;
          exc_d     = EX_INSTR_ACCESS_FAULT;
          exc_vld_d = 1'b1;
          state_d   = S_PARK;
        end else begin
          instr_d   = item_data;
          exc_d     = ex_code_t'(0);
          exc_vld_d = 1'b0;
          pc_d      = pc_incr(pc_q);
          state_d   = S_REQ;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_REQ;
      pc_q       <= RESET_VECTOR;
      pc_out_q   <= 32'h0;
      instr_q    <= NOP_INSTR;
      exc_q      <= ex_code_t'(0);
      exc_vld_q  <= 1'b0;
      pov_q      <= 1'b0;
      hold_vld_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      pc_out_q   <= pc_out_d;
      instr_q    <= instr_d;
      exc_q      <= exc_d;
      exc_vld_q  <= exc_vld_d;
      pov_q      <= pov_d;
      hold_vld_q <= hold_vld_d;
    end
  end

  // Buffer payload is qualified by hold_vld_q, so it needs no reset.
  always_ff @(posedge clk) begin
    hold_data_q <= hold_data_d;
    hold_err_q  <= hold_err_d;
    hold_pc_q   <= hold_pc_d;
  end

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_count_q, fetch_count_d;

  always_comb begin
    fetch_count_d = fetch_count_q;
    if (!flush && deliver && !item_err) begin
      fetch_count_d = fetch_count_q + 32'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_count_q <= 32'h0;
    end else begin
      fetch_count_q <= fetch_count_d;
    end
  end

  assign fetch_count = fetch_count_q;
`endif

endmodule

// File: tb/tb_fetch.sv
module tb_fetch;
  import fetch_pkg::*;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  // Main instance (RESET_VECTOR = 0)
  logic        reset;
  logic        req_valid, req_ready;
  logic [31:0] addr;
  logic        resp_valid, resp_err;
  logic [31:0] resp_data;
  logic [31:0] pc_out, instr_out;
  ex_code_t    exc_out;
  logic        exc_vld, pov;
  logic        stall, flush;
  logic [31:0] redirect_pc;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fcount;
`endif

  // Wrap-around instance (RESET_VECTOR = 0xFFFF_FFFC)
  logic        reset6;
  logic        req_valid6, req_ready6;
  logic [31:0] addr6;
  logic        resp_valid6;
  logic [31:0] resp_data6;
  logic [31:0] pc_out6, instr_out6;
  ex_code_t    exc_out6;
  logic        exc_vld6, pov6;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fcount6;
`endif

  fetch #(.RESET_VECTOR(32'h0000_0000)) u_dut (
    .clk(clk), .reset(reset),
    .imem_req_valid(req_valid), .imem_req_ready(req_ready), .imem_addr(addr),
    .imem_resp_valid(resp_valid), .imem_resp_data(resp_data), .imem_resp_err(resp_err),
    .PC_out(pc_out), .instr_out(instr_out),
    .exception_out(exc_out), .exception_out_valid(exc_vld),
    .pipeline_out_valid(pov),
    .stall(stall), .flush(flush), .redirect_pc(redirect_pc)
`ifdef FETCH_PERF_CNT_EN
    , .fetch_count(fcount)
`endif
  );

  fetch #(.RESET_VECTOR(32'hFFFF_FFFC)) u_dut6 (
    .clk(clk), .reset(reset6),
    .imem_req_valid(req_valid6), .imem_req_ready(req_ready6), .imem_addr(addr6),
    .imem_resp_valid(resp_valid6), .imem_resp_data(resp_data6), .imem_resp_err(1'b0),
    .PC_out(pc_out6), .instr_out(instr_out6),
    .exception_out(exc_out6), .exception_out_valid(exc_vld6),
    .pipeline_out_valid(pov6),
    .stall(1'b0), .flush(1'b0), .redirect_pc(32'h0)
`ifdef FETCH_PERF_CNT_EN
    , .fetch_count(fcount6)
`endif
  );

  typedef struct {
    logic        st;
    logic        fl;
    logic [31:0] rd;
    logic        rdy;
    logic        rv;
    logic [31:0] rdat;
    logic        re;
    logic        xreq;
    logic [31:0] xaddr;
    logic        xpov;
    logic [31:0] xpc;
    logic [31:0] xins;
    logic        xexv;
    ex_code_t    xex;
  } vec_t;

  vec_t vecs[$];
  int   n_vec = 0;
  int   n_bad = 0;

  function automatic vec_t mk(input logic st, input logic fl, input logic [31:0] rd,
                              input logic rdy, input logic rv, input logic [31:0] rdat,
                              input logic re, input logic xreq, input logic [31:0] xaddr,
                              input logic xpov, input logic [31:0] xpc,
                              input logic [31:0] xins, input logic xexv, input ex_code_t xex);
    vec_t v;
    v.st = st; v.fl = fl; v.rd = rd; v.rdy = rdy; v.rv = rv; v.rdat = rdat; v.re = re;
    v.xreq = xreq; v.xaddr = xaddr; v.xpov = xpov; v.xpc = xpc; v.xins = xins;
    v.xexv = xexv; v.xex = xex;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  localparam ex_code_t MIS = EX_INSTR_MISALIGNED;
  localparam ex_code_t AF  = EX_INSTR_ACCESS_FAULT;
  localparam ex_code_t EZ  = ex_code_t'(0);

  initial begin
    //         st fl rd           rdy rv rdat          re  xreq xaddr        xpov xpc          xins         xexv xex
    // 1: back-to-back fetches, valid every second cycle
    vecs.push_back(mk(0,0,32'h0,  1,0,32'h0,        0,  1,32'h0,   0,32'h0,   32'h13,      0,EZ)); // 0
    vecs.push_back(mk(0,0,32'h0,  0,1,32'h00500093, 0,  0,32'h0,   1,32'h0,   32'h00500093,0,EZ)); // 1
    vecs.push_back(mk(0,0,32'h0,  1,0,32'h0,        0,  1,32'h4,   0,32'h0,   32'h00500093,0,EZ)); // 2
    vecs.push_back(mk(0,0,32'h0,  0,1,32'h00500093, 0,  0,32'h4,   1,32'h4,   32'h00500093,0,EZ)); // 3
    vecs.push_back(mk(0,0,32'h0,  1,0,32'h0,        0,  1,32'h8,   0,32'h4,   32'h00500093,0,EZ)); // 4
    vecs.push_back(mk(0,0,32'h0,  0,1,32'h00200193, 0,  0,32'h8,   1,32'h8,   32'h00200193,0,EZ)); // 5
    // 2: stall while the response arrives, then release
    vecs.push_back(mk(0,0,32'h0,  1,0,32'h0,        0,  1,32'hC,   0,32'h8,   32'h00200193,0,EZ)); // 6
    vecs.push_back(mk(1,0,32'h0,  0,1,32'h00A00113, 0,  0,32'hC,   0,32'h8,   32'h00200193,0,EZ)); // 7
    vecs.push_back(mk(1,0,32'h0,  0,0,32'h0,        0,  0,32'hC,   0,32'h8,   32'h00200193,0,EZ)); // 8
    vecs.push_back(mk(1,0,32'h0,  0,0,32'h0,        0,  0,32'hC,   0,32'h8,   32'h00200193,0,EZ)); // 9
    vecs.push_back(mk(0,0,32'h0,  0,0,32'h0,        0,  0,32'hC,   1,32'hC,   32'h00A00113,0,EZ)); // 10
    vecs.push_back(mk(1,0,32'h0,  0,0,32'h0,        0,  1,32'h10,  1,32'hC,   32'h00A00113,0,EZ)); // 11
    vecs.push_back(mk(0,0,32'h0,  0,0,32'h0,        0,  1,32'h10,  0,32'hC,   32'h00A00113,0,EZ)); // 12
    vecs.push_back(mk(0,0,32'h0,  1,0,32'h0,        0,  1,32'h10,  0,32'hC,   32'h00A00113,0,EZ)); // 13
    // 3: flush in WAIT, late response dropped
    vecs.push_back(mk(0,1,32'h100,0,0,32'h0,        0,  0,32'h10,  0,32'hC,   32'h00A00113,0,EZ)); // 14
    vecs.push_back(mk(0,0,32'h0,  0,0,32'h0,        0,  0,32'h100, 0,32'hC,   32'h00A00113,0,EZ)); // 15
    vecs.push_back(mk(0,0,32'h0,  0,1,32'hDEADBEEF, 0,  0,32'h100, 0,32'hC,   32'h00A00113,0,EZ)); // 16
    vecs.push_back(mk(0,0,32'h0,  1,0,32'h0,        0,  1,32'h100, 0,32'hC,   32'h00A00113,0,EZ)); // 17
    vecs.push_back(mk(0,0,32'h0,  0,1,32'h00300213, 0,  0,32'h100, 1,32'h100, 32'h00300213,0,EZ)); // 18
    // 4: flush to a misaligned PC
    vecs.push_back(mk(0,1,32'h102,0,0,32'h0,        0,  1,32'h104, 0,32'h100, 32'h00300213,0,EZ)); // 19
    vecs.push_back(mk(0,0,32'h0,  0,0,32'h0,        0,  0,32'h102, 1,32'h102, 32'h13,      1,MIS)); // 20
    vecs.push_back(mk(0,0,32'h0,  1,0,32'h0,        0,  0,32'h102, 0,32'h102, 32'h13,      1,MIS)); // 21
    vecs.push_back(mk(0,0,32'h0,  1,0,32'h0,        0,  0,32'h102, 0,32'h102, 32'h13,      1,MIS)); // 22
    // 5: access fault at 0x20, park, flush to 0 resumes
    vecs.push_back(mk(0,1,32'h20, 0,0,32'h0,        0,  0,32'h102, 0,32'h102, 32'h13,      1,MIS)); // 23
    vecs.push_back(mk(0,0,32'h0,  1,0,32'h0,        0,  1,32'h20,  0,32'h102, 32'h13,      1,MIS)); // 24
    vecs.push_back(mk(0,0,32'h0,  0,1,32'h12345678, 1,  0,32'h20,  1,32'h20,  32'h13,      1,AF));  // 25
    vecs.push_back(mk(0,0,32'h0,  1,0,32'h0,        0,  0,32'h20,  0,32'h20,  32'h13,      1,AF));  // 26
    vecs.push_back(mk(0,1,32'h0,  0,0,32'h0,        0,  0,32'h20,  0,32'h20,  32'h13,      1,AF));  // 27
    vecs.push_back(mk(0,0,32'h0,  1,0,32'h0,        0,  1,32'h0,   0,32'h20,  32'h13,      1,AF));  // 28
    vecs.push_back(mk(0,0,32'h0,  0,1,32'h00500093, 0,  0,32'h0,   1,32'h0,   32'h00500093,0,EZ)); // 29
    // flush in the same cycle as a request handshake
    vecs.push_back(mk(0,1,32'h40, 1,0,32'h0,        0,  1,32'h4,   0,32'h0,   32'h00500093,0,EZ)); // 30
    vecs.push_back(mk(0,0,32'h0,  0,1,32'h11111111, 0,  0,32'h40,  0,32'h0,   32'h00500093,0,EZ)); // 31
    vecs.push_back(mk(0,0,32'h0,  1,0,32'h0,        0,  1,32'h40,  0,32'h0,   32'h00500093,0,EZ)); // 32
    vecs.push_back(mk(0,0,32'h0,  0,1,32'h00400293, 0,  0,32'h40,  1,32'h40,  32'h00400293,0,EZ)); // 33

    reset = 1'b1; stall = 1'b0; flush = 1'b0; redirect_pc = 32'h0;
    req_ready = 1'b0; resp_valid = 1'b0; resp_data = 32'h0; resp_err = 1'b0;
    reset6 = 1'b1; req_ready6 = 1'b0; resp_valid6 = 1'b0; resp_data6 = 32'h0;

    repeat (2) @(posedge clk);
    #1;
    chk("reset.pov",   32'(pov),       32'h0);
    chk("reset.pc",    pc_out,         32'h0);
    chk("reset.instr", instr_out,      32'h13);
    chk("reset.exv",   32'(exc_vld),   32'h0);
    chk("reset.ex",    32'(exc_out),   32'h0);
    chk("reset.req",   32'(req_valid), 32'h1);
    chk("reset.addr",  addr,           32'h0);
    reset = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      stall = vecs[i].st; flush = vecs[i].fl; redirect_pc = vecs[i].rd;
      req_ready = vecs[i].rdy; resp_valid = vecs[i].rv;
      resp_data = vecs[i].rdat; resp_err = vecs[i].re;
      #1;
      chk($sformatf("v%0d.req", i),  32'(req_valid), 32'(vecs[i].xreq));
      chk($sformatf("v%0d.addr", i), addr,           vecs[i].xaddr);
      @(posedge clk);
      #1;
      chk($sformatf("v%0d.pov", i),   32'(pov),     32'(vecs[i].xpov));
      chk($sformatf("v%0d.pc", i),    pc_out,       vecs[i].xpc);
      chk($sformatf("v%0d.instr", i), instr_out,    vecs[i].xins);
      chk($sformatf("v%0d.exv", i),   32'(exc_vld), 32'(vecs[i].xexv));
      chk($sformatf("v%0d.ex", i),    32'(exc_out), 32'(vecs[i].xex));
    end
    stall = 1'b0; flush = 1'b0; req_ready = 1'b0; resp_valid = 1'b0; resp_err = 1'b0;

    // Asynchronous reset mid-cycle: outputs clear without a clock edge.
    reset = 1'b1;
    #2;
    chk("areset.pov",   32'(pov),     32'h0);
    chk("areset.pc",    pc_out,       32'h0);
    chk("areset.instr", instr_out,    32'h13);
    chk("areset.addr",  addr,         32'h0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    // 6: PC wrap from 0xFFFF_FFFC to 0
    reset6 = 1'b0;
    req_ready6 = 1'b1;
    #1;
    chk("wrap.req0",  32'(req_valid6), 32'h1);
    chk("wrap.addr0", addr6,           32'hFFFF_FFFC);
    @(posedge clk); #1;
    req_ready6 = 1'b0; resp_valid6 = 1'b1; resp_data6 = 32'h00100093;
    @(posedge clk); #1;
    chk("wrap.pov0",  32'(pov6),  32'h1);
    chk("wrap.pc0",   pc_out6,    32'hFFFF_FFFC);
    chk("wrap.ins0",  instr_out6, 32'h00100093);
    resp_valid6 = 1'b0; req_ready6 = 1'b1;
    #1;
    chk("wrap.req1",  32'(req_valid6), 32'h1);
    chk("wrap.addr1", addr6,           32'h0);
    @(posedge clk); #1;
    req_ready6 = 1'b0; resp_valid6 = 1'b1; resp_data6 = 32'h00200113;
    @(posedge clk); #1;
    resp_valid6 = 1'b0;
    chk("wrap.pov1",  32'(pov6),  32'h1);
    chk("wrap.pc1",   pc_out6,    32'h0);
    chk("wrap.ins1",  instr_out6, 32'h00200113);
`ifdef FETCH_PERF_CNT_EN
    chk("wrap.count", fcount6,    32'h2);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
